// File: rtl/mem_stage_if.sv
// EX-to-MEM bus and the forwarding/write-back outputs of the memory stage.
interface mem_stage_if;
  logic [31:0] alu_result_ex;
  logic [31:0] rs2_data_ex_out;
  logic [4:0]  rd_ex_out;
  logic        regwrite_ex_out;
  logic        memread_ex;
  logic        memwrite_ex;
  logic        memtoreg_ex;
  logic [2:0]  loadtype_ex;
  logic [2:0]  strtype_ex;
  logic        flush_ex_mem;

  logic [31:0] alu_result_mem;
  logic [4:0]  rd_mem_out;
  logic        regwrite_mem_out;
  logic [31:0] alu_result_wb;
  logic [4:0]  rd_wb_out;
  logic        regwrite_wb_out;
  logic [31:0] wb_data;
  logic        misalign_err;

  modport master (
    output alu_result_ex, rs2_data_ex_out, rd_ex_out, regwrite_ex_out,
           memread_ex, memwrite_ex, memtoreg_ex, loadtype_ex, strtype_ex,
           flush_ex_mem,
    input  alu_result_mem, rd_mem_out, regwrite_mem_out, alu_result_wb,
           rd_wb_out, regwrite_wb_out, wb_data, misalign_err
  );

  modport slave (
    input  alu_result_ex, rs2_data_ex_out, rd_ex_out, regwrite_ex_out,
           memread_ex, memwrite_ex, memtoreg_ex, loadtype_ex, strtype_ex,
           flush_ex_mem,
    output alu_result_mem, rd_mem_out, regwrite_mem_out, alu_result_wb,
           rd_wb_out, regwrite_wb_out, wb_data, misalign_err
  );
endinterface

// File: rtl/mem_stage.sv
// Pipeline memory stage: EX/MEM register, byte-lane data memory, MEM/WB register.
// Loads read the array asynchronously; stores commit at the end of the MEM cycle.
module mem_stage #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic        clk,
  input  logic        rst,
  mem_stage_if.slave  bus
);

  logic [31:0] alu_q, alu_d;
  logic [31:0] rs2_q, rs2_d;
  logic [4:0]  rd_q, rd_d;
  logic        rw_q, rw_d;
  logic        mr_q, mr_d;
  logic        mw_q, mw_d;
  logic        m2r_q, m2r_d;
  logic [2:0]  lt_q, lt_d;
  logic [2:0]  st_q, st_d;

  logic [31:0] alu_wb_q;
  logic [31:0] ld_wb_q;
  logic [4:0]  rd_wb_q;
  logic        rw_wb_q;
  logic        m2r_wb_q;
  logic        err_q;

  logic [31:0] mem_q [DEPTH];

  logic [AW-1:0] widx_s;
  logic [1:0]    off_s;
  logic          ld_mis_s, st_mis_s, load_mis_s, store_mis_s;
  logic [3:0]    be_s;
  logic [31:0]   wdata_s;
  logic          we_s;
  logic [31:0]   rdata_s;
  logic [7:0]    byte_s;
  logic [15:0]   half_s;
  logic [31:0]   load_data_s;
  logic          rw_gated_s;

  always_comb begin
    if (bus.flush_ex_mem) begin
      alu_d = 32'h0; rs2_d = 32'h0; rd_d = 5'd0; rw_d = 1'b0;
      mr_d  = 1'b0;  mw_d  = 1'b0;  m2r_d = 1'b0; lt_d = 3'd0; st_d = 3'd0;
    end else begin
      alu_d = bus.alu_result_ex;   rs2_d = bus.rs2_data_ex_out;
      rd_d  = bus.rd_ex_out;       rw_d  = bus.regwrite_ex_out;
      mr_d  = bus.memread_ex;      mw_d  = bus.memwrite_ex;
      m2r_d = bus.memtoreg_ex;     lt_d  = bus.loadtype_ex;
      st_d  = bus.strtype_ex;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      alu_q <= 32'h0; rs2_q <= 32'h0; rd_q <= 5'd0; rw_q <= 1'b0;
      mr_q  <= 1'b0;  mw_q  <= 1'b0;  m2r_q <= 1'b0; lt_q <= 3'd0; st_q <= 3'd0;
    end else begin
      alu_q <= alu_d; rs2_q <= rs2_d; rd_q <= rd_d; rw_q <= rw_d;
      mr_q  <= mr_d;  mw_q  <= mw_d;  m2r_q <= m2r_d; lt_q <= lt_d; st_q <= st_d;
    end
  end

  assign widx_s = alu_q[AW+1:2];
  assign off_s  = alu_q[1:0];

  // Alignment rules: half needs an even offset, word needs offset zero; bytes never fault.
  always_comb begin
    case (lt_q)
      3'd1, 3'd5: ld_mis_s = off_s[0];
      3'd2:       ld_mis_s = (off_s != 2'd0);
      default:    ld_mis_s = 1'b0;
    endcase
    case (st_q)
      3'd1:    st_mis_s = off_s[0];
      3'd2:    st_mis_s = (off_s != 2'd0);
      default: st_mis_s = 1'b0;
    endcase
  end

  assign load_mis_s  = mr_q & ld_mis_s;
  assign store_mis_s = mw_q & st_mis_s;
  assign rw_gated_s  = rw_q & ~load_mis_s;

  always_comb begin
    case (st_q)
      3'd0: begin
        be_s    = 4'b0001 << off_s;
        wdata_s = {4{rs2_q[7:0]}};
      end
      3'd1: begin
        be_s    = off_s[1] ? 4'b1100 : 4'b0011;
        wdata_s = {2{rs2_q[15:0]}};
      end
      3'd2: begin
        be_s    = 4'b1111;
        wdata_s = rs2_q;
      end
      default: begin
        be_s    = 4'b0000;
        wdata_s = 32'h0;
      end
    endcase
  end

  assign we_s = mw_q & ~store_mis_s & ~rst;

  always_ff @(posedge clk) begin
    if (we_s) begin
      for (int i = 0; i < 4; i++) begin
        if (be_s[i]) begin
          mem_q[widx_s][8*i +: 8] <= wdata_s[8*i +: 8];
        end
      end
    end
  end

  // Read happens before the same-cycle store lands, so read+write returns the old word.
  assign rdata_s = mem_q[widx_s];

  always_comb begin
    case (off_s)
      2'd0:    byte_s = rdata_s[7:0];
      2'd1:    byte_s = rdata_s[15:8];
      2'd2:    byte_s = rdata_s[23:16];
      2'd3:    byte_s = rdata_s[31:24];
      default: byte_s = 8'h0;
    endcase
    half_s = off_s[1] ? rdata_s[31:16] : rdata_s[15:0];
    case (lt_q)
      3'd0:    load_data_s = {{24{byte_s[7]}}, byte_s};
      3'd1:    load_data_s = {{16{half_s[15]}}, half_s};
      3'd2:    load_data_s = rdata_s;
      3'd4:    load_data_s = {24'h0, byte_s};
      3'd5:    load_data_s = {16'h0, half_s};
      default: load_data_s = 32'h0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      alu_wb_q <= 32'h0; ld_wb_q <= 32'h0; rd_wb_q <= 5'd0;
      rw_wb_q  <= 1'b0;  m2r_wb_q <= 1'b0; err_q <= 1'b0;
    end else begin
      alu_wb_q <= alu_q;      ld_wb_q  <= load_data_s; rd_wb_q <= rd_q;
      rw_wb_q  <= rw_gated_s; m2r_wb_q <= m2r_q;
      err_q    <= load_mis_s | store_mis_s;
    end
  end

  assign bus.alu_result_mem   = alu_q;
  assign bus.rd_mem_out       = rd_q;
  assign bus.regwrite_mem_out = rw_gated_s;
  assign bus.alu_result_wb    = alu_wb_q;
  assign bus.rd_wb_out        = rd_wb_q;
  assign bus.regwrite_wb_out  = rw_wb_q;
  assign bus.wb_data          = m2r_wb_q ? ld_wb_q : alu_wb_q;
  assign bus.misalign_err     = err_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed stimulus with a due-cycle scoreboard; a negedge monitor checks MEM, WB,
// error and reset expectations as the pipeline presents them.
module tb_mem_stage;
  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  mem_stage_if bus();
  mem_stage #(.DEPTH(1024), .AW(10)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          due;
    int          kind;   // 0 MEM, 1 WB, 2 ERR, 3 all-zero
    string       nm;
    logic [31:0] data;
    logic [31:0] alu;
    logic [4:0]  rd;
    logic        rw;
    logic        dc;
  } exp_t;

  exp_t sb_q[$];

  task automatic check(input exp_t e);
    logic ok;
    checks++;
    case (e.kind)
      0: ok = (bus.alu_result_mem === e.alu) && (bus.rd_mem_out === e.rd) &&
              (bus.regwrite_mem_out === e.rw);
      1: ok = (e.dc || (bus.wb_data === e.data)) && (bus.alu_result_wb === e.alu) &&
              (bus.rd_wb_out === e.rd) && (bus.regwrite_wb_out === e.rw);
      2: ok = (bus.misalign_err === e.rw);
      default: ok = (bus.alu_result_mem === 32'h0) && (bus.rd_mem_out === 5'd0) &&
                    (bus.regwrite_mem_out === 1'b0) && (bus.alu_result_wb === 32'h0) &&
                    (bus.rd_wb_out === 5'd0) && (bus.regwrite_wb_out === 1'b0) &&
                    (bus.wb_data === 32'h0) && (bus.misalign_err === 1'b0);
    endcase
    if (!ok) begin
      errors++;
      $display("FAIL %s kind=%0d cyc=%0d got mem(alu=%h rd=%0d rw=%b) wb(data=%h alu=%h rd=%0d rw=%b) err=%b exp data=%h alu=%h rd=%0d rw/err=%b",
               e.nm, e.kind, cyc, bus.alu_result_mem, bus.rd_mem_out, bus.regwrite_mem_out,
               bus.wb_data, bus.alu_result_wb, bus.rd_wb_out, bus.regwrite_wb_out,
               bus.misalign_err, e.data, e.alu, e.rd, e.rw);
    end
  endtask

  always @(negedge clk) begin
    int i;
    i = 0;
    while (i < sb_q.size()) begin
      if (sb_q[i].due == cyc) begin
        check(sb_q[i]);
        sb_q.delete(i);
      end else begin
        i++;
      end
    end
  end

  task automatic drive(input logic [31:0] alu, input logic [31:0] rs2, input logic [4:0] rd,
                       input logic rw, input logic mr, input logic mw, input logic m2r,
                       input logic [2:0] lt, input logic [2:0] st, input logic fl);
    bus.alu_result_ex   = alu;
    bus.rs2_data_ex_out = rs2;
    bus.rd_ex_out       = rd;
    bus.regwrite_ex_out = rw;
    bus.memread_ex      = mr;
    bus.memwrite_ex     = mw;
    bus.memtoreg_ex     = m2r;
    bus.loadtype_ex     = lt;
    bus.strtype_ex      = st;
    bus.flush_ex_mem    = fl;
  endtask

  task automatic ins(input string nm, input logic [31:0] alu, input logic [31:0] rs2,
                     input logic [4:0] rd, input logic rw, input logic mr, input logic mw,
                     input logic m2r, input logic [2:0] lt, input logic [2:0] st,
                     input logic fl, input logic [31:0] wbx, input logic mis, input logic dc);
    exp_t e;
    rst = 1'b0;
    drive(alu, rs2, rd, rw, mr, mw, m2r, lt, st, fl);
    e.nm   = nm;
    e.alu  = fl ? 32'h0 : alu;
    e.rd   = fl ? 5'd0 : rd;
    e.rw   = fl ? 1'b0 : (rw & ~(mr & mis));
    e.data = wbx;
    e.dc   = dc;
    e.due  = cyc + 1; e.kind = 0; sb_q.push_back(e);
    e.due  = cyc + 2; e.kind = 1; sb_q.push_back(e);
    e.kind = 2; e.rw = mis; sb_q.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic rst_step(input string nm, input logic [31:0] alu, input logic [31:0] rs2,
                          input logic mw, input logic [2:0] st);
    exp_t e;
    rst = 1'b1;
    drive(alu, rs2, 5'd0, 1'b0, 1'b0, mw, 1'b0, 3'd0, st, 1'b0);
    e.nm = nm; e.alu = 32'h0; e.rd = 5'd0; e.rw = 1'b0; e.data = 32'h0; e.dc = 1'b0;
    e.due = cyc + 1; e.kind = 3; sb_q.push_back(e);
    @(posedge clk); #1;
  endtask

  initial begin
    rst_step("reset0", 32'h0, 32'h0, 1'b0, 3'd0);
    rst_step("reset1", 32'h0, 32'h0, 1'b0, 3'd0);
    //   name      alu           rs2           rd    rw    mr    mw    m2r   lt    st    fl    wb_data       mis   dc
    ins("sw10",    32'h10,       32'hDEADBEEF, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 3'd2, 1'b0, 32'h10,       1'b0, 1'b0);
    ins("lw10",    32'h10,       32'h0,        5'd5, 1'b1, 1'b1, 1'b0, 1'b1, 3'd2, 3'd0, 1'b0, 32'hDEADBEEF, 1'b0, 1'b0);
    ins("sb11",    32'h11,       32'h7F,       5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 3'd0, 1'b0, 32'h11,       1'b0, 1'b0);
    ins("sh12",    32'h12,       32'h8001,     5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 3'd1, 1'b0, 32'h12,       1'b0, 1'b0);
    ins("lw_mix",  32'h10,       32'h0,        5'd5, 1'b1, 1'b1, 1'b0, 1'b1, 3'd2, 3'd0, 1'b0, 32'h80017FEF, 1'b0, 1'b0);
    ins("lb12",    32'h12,       32'h0,        5'd6, 1'b1, 1'b1, 1'b0, 1'b1, 3'd0, 3'd0, 1'b0, 32'h00000001, 1'b0, 1'b0);
    ins("lh12",    32'h12,       32'h0,        5'd7, 1'b1, 1'b1, 1'b0, 1'b1, 3'd1, 3'd0, 1'b0, 32'hFFFF8001, 1'b0, 1'b0);
    ins("lhu12",   32'h12,       32'h0,        5'd8, 1'b1, 1'b1, 1'b0, 1'b1, 3'd5, 3'd0, 1'b0, 32'h00008001, 1'b0, 1'b0);
    ins("lb13",    32'h13,       32'h0,        5'd8, 1'b1, 1'b1, 1'b0, 1'b1, 3'd0, 3'd0, 1'b0, 32'hFFFFFF80, 1'b0, 1'b0);
    ins("lbu13",   32'h13,       32'h0,        5'd8, 1'b1, 1'b1, 1'b0, 1'b1, 3'd4, 3'd0, 1'b0, 32'h00000080, 1'b0, 1'b0);
    ins("alu_rd3", 32'h1234,     32'h0,        5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 32'h1234,     1'b0, 1'b0);
    ins("sh13_mis",32'h13,       32'hFFFF,     5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 3'd1, 1'b0, 32'h13,       1'b1, 1'b0);
    ins("nop_a",   32'h0,        32'h0,        5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 32'h0,        1'b0, 1'b0);
    ins("lw02_mis",32'h02,       32'h0,        5'd9, 1'b1, 1'b1, 1'b0, 1'b1, 3'd2, 3'd0, 1'b0, 32'h0,        1'b1, 1'b1);
    ins("nop_b",   32'h0,        32'h0,        5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 32'h0,        1'b0, 1'b0);
    ins("lw_after",32'h10,       32'h0,        5'd5, 1'b1, 1'b1, 1'b0, 1'b1, 3'd2, 3'd0, 1'b0, 32'h80017FEF, 1'b0, 1'b0);
    ins("flush_sw",32'h10,       32'h11111111, 5'd4, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 3'd2, 1'b1, 32'h0,        1'b0, 1'b0);
    ins("lw_flush",32'h10,       32'h0,        5'd5, 1'b1, 1'b1, 1'b0, 1'b1, 3'd2, 3'd0, 1'b0, 32'h80017FEF, 1'b0, 1'b0);
    ins("sw_wrap", 32'h1010,     32'hA5A5A5A5, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 3'd2, 1'b0, 32'h1010,     1'b0, 1'b0);
    ins("rdwr",    32'h10,       32'h5A5A5A5A, 5'd10,1'b1, 1'b1, 1'b1, 1'b1, 3'd2, 3'd2, 1'b0, 32'hA5A5A5A5, 1'b0, 1'b0);
    ins("lw_new",  32'h10,       32'h0,        5'd5, 1'b1, 1'b1, 1'b0, 1'b1, 3'd2, 3'd0, 1'b0, 32'h5A5A5A5A, 1'b0, 1'b0);
    ins("sw20",    32'h20,       32'hCAFEF00D, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 3'd2, 1'b0, 32'h20,       1'b0, 1'b0);
    ins("nop_c",   32'h0,        32'h0,        5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 32'h0,        1'b0, 1'b0);
    rst_step("rst_sw20", 32'h20, 32'h12345678, 1'b1, 3'd2);
    ins("lw20",    32'h20,       32'h0,        5'd7, 1'b1, 1'b1, 1'b0, 1'b1, 3'd2, 3'd0, 1'b0, 32'hCAFEF00D, 1'b0, 1'b0);
    ins("lt_undef",32'h20,       32'h0,        5'd11,1'b1, 1'b1, 1'b0, 1'b1, 3'd3, 3'd0, 1'b0, 32'h0,        1'b0, 1'b0);
    ins("st_undef",32'h20,       32'h0,        5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 3'd3, 1'b0, 32'h20,       1'b0, 1'b0);
    ins("lw20_chk",32'h20,       32'h0,        5'd7, 1'b1, 1'b1, 1'b0, 1'b1, 3'd2, 3'd0, 1'b0, 32'hCAFEF00D, 1'b0, 1'b0);
    ins("nop_end", 32'h0,        32'h0,        5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 32'h0,        1'b0, 1'b0);
    repeat (4) begin
      @(posedge clk); #1;
    end
    while (sb_q.size() > 0) begin
      errors++;
      $display("FAIL %s never checked (due=%0d now=%0d)", sb_q[0].nm, sb_q[0].due, cyc);
      sb_q.delete(0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
